regfile_write_port: RTL and testbench
=====================================

// Module: regfile_write_port
// PURPOSE
//   Write side of the 32 x 64-bit register file; the counterpart of the two-port read mux.
//   Accepts write-back requests over a valid/ready handshake and buffers them in a small FIFO.
//   Commits one write per cycle into the register array, in order.
//   Drives the packed register array consumed by the read-side mux.
// PARAMETERS
//   DEPTH    2    write-queue entries; power of 2, >= 2
// PORTS
//   clk            in   1        single clock, rising edge
//   reset_n        in   1        asynchronous, active-low reset
//   wr_valid       in   1        write request present
//   wr_ready       out  1        queue can accept a request this cycle
//   wr_reg         in   5        destination register index
//   wr_data        in   64       write data
//   stall          in   1        1 = hold the commit side (no pop, no write)
//   regs           out  [31:0][63:0]  register array, regs[i] = Xi
//   pending        out  $clog2(DEPTH)+1  number of queued, uncommitted writes
// BEHAVIOUR
//   Reset: clock and reset_n only; reset is asynchronous and active-low.
//   - While reset_n=0: all regs = 0, queue empty, pending = 0, wr_ready = 1.
//   - Reset asserted mid-operation discards every queued write; the array clears to 0.
//   Accept: on a rising edge with wr_valid & wr_ready, {wr_reg, wr_data} is pushed at the tail.
//   Ready: wr_ready = (pending != DEPTH); registered only, with no combinational path from pop.
//   - A full queue refuses a push even in a cycle when it also pops.
//   Commit: on a rising edge with !stall & pending != 0, the head is popped and
//   regs[head.reg] <= head.data is written.
//   - The commit target is selected by the one-hot output of the write decoder.
//   Latency:
//   - A request accepted at edge N commits at edge N+1 at the earliest.
//   - The new value is visible on regs after edge N+1.
//   - Each stalled cycle adds one cycle of latency.
//   Simultaneous push and pop: both take effect and pending is unchanged.
//   - An empty queue never pops in the push cycle; there is no bypass.
//   Ordering: commits are in strict FIFO order, so the later write to the same register wins.
//   Pointers: head/tail are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - pending is tracked as a separate counter.
//   Pointer/counter invariant: 0 <= pending <= DEPTH.
//   - Push when full and pop when empty are impossible by construction.
//   No write ever touches more than one register per cycle.
//   The regs output is driven straight from flops, with no combinational logic after the array.
// CONFIGURATION
//   Macro REGFILE_XZR_EN
//   - Defined: X31 is hardwired zero.
//     - regs[31] is always 64'h0.
//     - A commit to index 31 still pops and decrements pending, but writes nothing.
//   - Undefined: X31 is an ordinary writable register with the same commit rules as X0..X30.
// STRUCTURE
//   Package regfile_pkg:
//   - NUM_REGS = 32
//   - XLEN = 64
//   - REG_IDX_W = 5
//   - ZERO_REG = 5'd31
//   - typedef struct packed { logic [4:0] idx; logic [63:0] data; } wb_req_t
//   - typedef logic [NUM_REGS-1:0][XLEN-1:0] reg_array_t
//   Sub-module write_decoder_5to32:
//   - 5-bit index plus enable in, 32-bit one-hot out.
//   - Output is all-zero when the enable is 0.
//   - Each register is a 64-bit flop bank gated by its decoder bit.
//   The queue is an array of wb_req_t, held in this module.
// TESTING
//   1. Reset checks:
//      - Pulse reset_n low asynchronously, mid-clock -> regs all 0, pending=0, wr_ready=1 immediately.
//      - Write X5=64'hDEAD_BEEF, stall=0 -> regs[5] updates one edge after accept; pending 1->0.
//   2. Stall=1 and push X1=1, X2=2 -> pending=2, wr_ready=0, third push refused.
//      - Drop stall -> X1 commits, then X2 on the next edge.
//   3. Back-to-back writes X7=A then X7=B -> regs[7] ends at B.
//      - Continuous valid with stall=0 sustains one write/cycle and pending stays <= 1.
//   4. Full queue with stall released while wr_valid=1 -> the full-cycle push is refused.
//      - The push is accepted on the next cycle, and no request is lost or duplicated.
//   5. Write X31=64'hFFFF:
//      - With REGFILE_XZR_EN defined -> regs[31] stays 0 and pending decrements.
//      - Without it -> regs[31]=64'hFFFF.
//   6. Queue two writes, then assert reset_n=0 before commit -> regs stay 0.
//      - pending=0, and neither write appears after reset release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write port.
// Both the write queue and the read-side mux consume these definitions.
package regfile_pkg;

    localparam int NUM_REGS  = 32;
    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
    } wb_req_t;

    typedef logic [NUM_REGS-1:0][XLEN-1:0] reg_array_t;

endpackage

// File: rtl/regfile_write_port_decoder.sv
// One-hot write-enable decoder for the register array.
// The output is all-zero when en is low, so an idle cycle enables no flop bank.
module write_decoder_5to32
    import regfile_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  sel
);

    always_comb begin
        sel = '0;
        if (en) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32 x 64-bit register file: a small in-order write queue feeding the array.
// Define REGFILE_XZR_EN to make X31 a hardwired zero register.
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [REG_IDX_W-1:0]   wr_reg,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   stall,
    output reg_array_t             regs,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

`ifdef REGFILE_XZR_EN
    localparam bit XZR = 1'b1;
`else
    localparam bit XZR = 1'b0;
`endif

    wb_req_t             queue [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic                ready_q;
    logic                push;
    logic                pop;
    wb_req_t             head_req;
    logic [NUM_REGS-1:0] sel;

    // Pop looks only at the registered count, so a push never bypasses into the same-cycle commit.
    assign push     = wr_valid & ready_q;
    assign pop      = ~stall & (count != '0);
    assign head_req = queue[head];

    assign wr_ready = ready_q;
    assign pending  = count;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count   <= count_next;
            ready_q <= (count_next != FULL);
        end
    end

    // Queue storage needs no reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            queue[tail] <= wb_req_t'{idx: wr_reg, data: wr_data};
        end
    end

    write_decoder_5to32 u_dec (
        .idx (head_req.idx),
        .en  (pop),
        .sel (sel)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bank
        if (XZR && (i == int'(ZERO_REG))) begin : g_zero
            logic unused_sel;
            assign unused_sel = sel[i];
            assign regs[i]    = '0;
        end else begin : g_flop
            logic [XLEN-1:0] q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q <= '0;
                end else if (sel[i]) begin
                    q <= head_req.data;
                end
            end
            assign regs[i] = q;
        end
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: a vector table for single-cycle behaviour plus
// hand-written reset sequences. Expected values are written out by hand per vector.
module tb_regfile_write_port;
    import regfile_pkg::*;

`ifdef REGFILE_XZR_EN
    localparam logic [63:0] EXP_X31 = 64'h0;
`else
    localparam logic [63:0] EXP_X31 = 64'hFFFF;
`endif

    logic        clk;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_reg;
    logic [63:0] wr_data;
    logic        stall;
    reg_array_t  regs;
    logic [1:0]  pending;

    int errors = 0;
    int checks = 0;

    regfile_write_port #(.DEPTH(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_reg   (wr_reg),
        .wr_data  (wr_data),
        .stall    (stall),
        .regs     (regs),
        .pending  (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic [4:0]  idx;
        logic [63:0] data;
        logic        stall;
        logic        exp_ready;
        logic [1:0]  exp_pending;
        logic [4:0]  chk_idx;
        logic [63:0] exp_val;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [4:0] i, logic [63:0] d, logic s,
                                logic er, logic [1:0] ep, logic [4:0] ci, logic [63:0] ev);
        vec_t r;
        r.valid = v; r.idx = i; r.data = d; r.stall = s;
        r.exp_ready = er; r.exp_pending = ep; r.chk_idx = ci; r.exp_val = ev;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(string name);
        int nz;
        nz = 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (regs[r] !== 64'h0) nz++;
        end
        check(name, 64'(nz), 64'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // valid idx data stall | ready pending chk_idx exp_val
        vecs.push_back(mk(1, 5'd5,  64'hDEAD_BEEF, 0, 1, 2'd1, 5'd5,  64'h0));
        vecs.push_back(mk(0, 5'd0,  64'h0,         0, 1, 2'd0, 5'd5,  64'hDEAD_BEEF));
        vecs.push_back(mk(1, 5'd1,  64'h1,         1, 1, 2'd1, 5'd1,  64'h0));
        vecs.push_back(mk(1, 5'd2,  64'h2,         1, 0, 2'd2, 5'd2,  64'h0));
        vecs.push_back(mk(1, 5'd3,  64'h3,         1, 0, 2'd2, 5'd3,  64'h0));
        vecs.push_back(mk(0, 5'd0,  64'h0,         0, 1, 2'd1, 5'd1,  64'h1));
        vecs.push_back(mk(0, 5'd0,  64'h0,         0, 1, 2'd0, 5'd2,  64'h2));
        vecs.push_back(mk(0, 5'd0,  64'h0,         0, 1, 2'd0, 5'd3,  64'h0));
        vecs.push_back(mk(1, 5'd7,  64'hA,         0, 1, 2'd1, 5'd7,  64'h0));
        vecs.push_back(mk(1, 5'd7,  64'hB,         0, 1, 2'd1, 5'd7,  64'hA));
        vecs.push_back(mk(0, 5'd0,  64'h0,         0, 1, 2'd0, 5'd7,  64'hB));
        vecs.push_back(mk(1, 5'd8,  64'h8,         0, 1, 2'd1, 5'd8,  64'h0));
        vecs.push_back(mk(1, 5'd9,  64'h9,         0, 1, 2'd1, 5'd8,  64'h8));
        vecs.push_back(mk(1, 5'd10, 64'h10,        0, 1, 2'd1, 5'd9,  64'h9));
        vecs.push_back(mk(0, 5'd0,  64'h0,         0, 1, 2'd0, 5'd10, 64'h10));
        vecs.push_back(mk(1, 5'd11, 64'h11,        1, 1, 2'd1, 5'd11, 64'h0));
        vecs.push_back(mk(1, 5'd12, 64'h12,        1, 0, 2'd2, 5'd12, 64'h0));
        vecs.push_back(mk(1, 5'd13, 64'h13,        0, 1, 2'd1, 5'd11, 64'h11));
        vecs.push_back(mk(1, 5'd13, 64'h13,        0, 1, 2'd1, 5'd12, 64'h12));
        vecs.push_back(mk(0, 5'd0,  64'h0,         0, 1, 2'd0, 5'd13, 64'h13));
        vecs.push_back(mk(0, 5'd0,  64'h0,         0, 1, 2'd0, 5'd13, 64'h13));
        vecs.push_back(mk(1, 5'd31, 64'hFFFF,      0, 1, 2'd1, 5'd31, 64'h0));
        vecs.push_back(mk(0, 5'd0,  64'h0,         0, 1, 2'd0, 5'd31, EXP_X31));
        vecs.push_back(mk(0, 5'd0,  64'h0,         0, 1, 2'd0, 5'd0,  64'h0));

        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_reg   = '0;
        wr_data  = '0;
        stall    = 1'b0;
        #7;
        check("reset_pending", 64'(pending), 64'h0);
        check("reset_ready", 64'(wr_ready), 64'h1);
        check_all_zero("reset_regs");
        #6 reset_n = 1'b1;
        step();

        for (int n = 0; n < vecs.size(); n++) begin
            wr_valid = vecs[n].valid;
            wr_reg   = vecs[n].idx;
            wr_data  = vecs[n].data;
            stall    = vecs[n].stall;
            step();
            check($sformatf("v%0d_ready", n), 64'(wr_ready), 64'(vecs[n].exp_ready));
            check($sformatf("v%0d_pending", n), 64'(pending), 64'(vecs[n].exp_pending));
            check($sformatf("v%0d_x%0d", n, vecs[n].chk_idx), regs[vecs[n].chk_idx], vecs[n].exp_val);
        end
        check("x1_untouched_after_stream", regs[1], 64'h1);

        // Asynchronous reset mid-cycle with a populated array
        wr_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("midreset_pending", 64'(pending), 64'h0);
        check("midreset_ready", 64'(wr_ready), 64'h1);
        check_all_zero("midreset_regs");
        #2 reset_n = 1'b1;
        step();

        // Queue two writes under stall, then reset before either commits
        stall    = 1'b1;
        wr_valid = 1'b1;
        wr_reg   = 5'd20;
        wr_data  = 64'h20;
        step();
        wr_reg   = 5'd21;
        wr_data  = 64'h21;
        step();
        check("queued_pending", 64'(pending), 64'h2);
        check("queued_ready", 64'(wr_ready), 64'h0);
        wr_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("qreset_pending", 64'(pending), 64'h0);
        check("qreset_ready", 64'(wr_ready), 64'h1);
        #2 reset_n = 1'b1;
        stall = 1'b0;
        step();
        step();
        step();
        check("qreset_x20", regs[20], 64'h0);
        check("qreset_x21", regs[21], 64'h0);
        check("qreset_pending_after", 64'(pending), 64'h0);
        check_all_zero("qreset_regs");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
